// File: rtl/ksa_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ksa_arbiter_if
// Purpose  : Requester/response bundle for the shared Kogge-Stone adder
//            arbiter. rsp_ovf exists only when KSA_ARB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ksa_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_cout;
`ifdef KSA_ARB_OVF_EN
    logic                  rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ksa_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : KSA_top / ksa_arbiter
// Purpose  : Round-robin arbiter sharing one registered 32-bit Kogge-Stone
//            add/sub datapath. Optional overflow flag: KSA_ARB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module KSA_top (
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic        i_cin,
    output logic      [31:0] o_sum,
    output logic             o_cout
);
    logic [31:0] w_b;
    logic [31:0] w_p;
    logic [31:0] w_gp;
    logic [31:0] w_pp;
    logic [31:0] w_gn;
    logic [31:0] w_pn;

    // cin=1 selects subtraction: B is inverted here and cin supplies the +1
    always_comb begin
        w_b      = i_cin ? ~i_b : i_b;
        w_p      = i_a ^ w_b;
        w_gp     = i_a & w_b;
        w_gp[0]  = w_gp[0] | (w_p[0] & i_cin);
        w_pp     = w_p;
        w_gn     = '0;
        w_pn     = '0;
        for (int l = 0; l < 5; l++) begin
            w_gn = w_gp;
            w_pn = w_pp;
            for (int i = (1 << l); i < 32; i++) begin
                w_gn[i] = w_gp[i] | (w_pp[i] & w_gp[i - (1 << l)]);
                w_pn[i] = w_pp[i] & w_pp[i - (1 << l)];
            end
            w_gp = w_gn;
            w_pp = w_pn;
        end
        o_sum  = w_p ^ {w_gp[30:0], i_cin};
        o_cout = w_gp[31];
    end
endmodule

module ksa_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ksa_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_op_id;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic               r_op_sub;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_rsp_sum;
    logic               r_rsp_cout;

    logic [ID_W:0]      w_idx_wide;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_found;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_sel_sub;
    logic [31:0]        w_sum;
    logic               w_cout;

    // Scan starting at the round-robin pointer, wrapping modulo NUM_REQ
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_idx_wide = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx_wide = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx_wide >= (ID_W+1)'(NUM_REQ)) begin
                w_idx_wide = w_idx_wide - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_idx_wide[ID_W-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_grant   = (r_state == S_IDLE) && w_found && !rst;

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_a   = bus.req_a[32*i +: 32];
                w_sel_b   = bus.req_b[32*i +: 32];
                w_sel_sub = bus.req_sub[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_req_ready = NUM_REQ'(1) << w_winner;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) begin
            w_req_ready = '0;
        end
    end

    KSA_top u_ksa (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .i_cin  (r_op_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_sub    <= 1'b0;
            r_op_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_sub <= w_sel_sub;
                r_op_id  <= w_winner;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_EXEC) begin
                r_rsp_sum   <= w_sum;
                r_rsp_cout  <= w_cout;
                r_rsp_id    <= r_op_id;
                r_rsp_valid <= 1'b1;
            end else if (r_state == S_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef KSA_ARB_OVF_EN
    logic r_rsp_ovf;
    logic w_ovf;

    // Signed overflow: result sign differs from A when operand signs allow it
    assign w_ovf = r_op_sub ? ((r_op_a[31] != r_op_b[31]) && (w_sum[31] != r_op_a[31]))
                            : ((r_op_a[31] == r_op_b[31]) && (w_sum[31] != r_op_a[31]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_ovf <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_ovf <= w_ovf;
        end
    end

    assign bus.rsp_ovf = r_rsp_ovf;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;
endmodule
`default_nettype wire

// File: tb/tb_ksa_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ksa_arbiter
// Purpose  : Directed and constrained-random self-checking bench for
//            ksa_arbiter (overflow checks active with KSA_ARB_OVF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ksa_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int N_RAND  = 300;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ksa_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    ksa_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] pa   [NUM_REQ];
    logic [31:0] pb   [NUM_REQ];
    logic        ps   [NUM_REQ];
    logic        pend [NUM_REQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (sub) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic pack();
        bus.req_a     = {pa[3], pa[2], pa[1], pa[0]};
        bus.req_b     = {pb[3], pb[2], pb[1], pb[0]};
        bus.req_sub   = {ps[3], ps[2], ps[1], ps[0]};
        bus.req_valid = {pend[3], pend[2], pend[1], pend[0]};
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        pack();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single-requester operation with hand-computed expectations
    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] es, input logic ec);
        logic [3:0] oh;
        oh       = 4'b0001 << id;
        pa[id]   = a;
        pb[id]   = b;
        ps[id]   = sub;
        pend[id] = 1'b1;
        bus.rsp_ready = 1'b1;
        pack();
        #1 check("op_grant", 64'(bus.req_ready), 64'(oh));
        @(negedge clk);
        pend[id] = 1'b0;
        pack();
        #1 check("op_exec_ready", 64'(bus.req_ready), 64'(0));
        check("op_exec_valid", 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        check("op_valid", 64'(bus.rsp_valid), 64'(1));
        check("op_sum", 64'(bus.rsp_sum), 64'(es));
        check("op_cout", 64'(bus.rsp_cout), 64'(ec));
        check("op_id", 64'(bus.rsp_id), 64'(id));
        @(negedge clk);
        check("op_done", 64'(bus.rsp_valid), 64'(0));
    endtask

    initial begin
        logic [3:0]  exp_rdy;
        logic [32:0] r;
        int          w;
        int          m_state;
        int          m_ptr;
        int          m_id;
        logic [32:0] m_res;
        int          n_ops;
        int          cyc;

        rst           = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pa[i] = '0; pb[i] = '0; ps[i] = 1'b0; pend[i] = 1'b1;
        end
        pack();
        @(negedge clk);
        @(negedge clk);
        #1 check("rst_ready", 64'(bus.req_ready), 64'(0));
        check("rst_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_sum", 64'(bus.rsp_sum), 64'(0));
        check("rst_id", 64'(bus.rsp_id), 64'(0));
        check("rst_cout", 64'(bus.rsp_cout), 64'(0));
        do_reset();

        do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0);
        do_op(2, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0);
        do_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);

        // All requesters valid: grant order 0,1,2,3,0,1 every third cycle
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            pa[i] = 32'(i + 10); pb[i] = 32'(i); ps[i] = 1'(i % 2); pend[i] = 1'b1;
        end
        pack();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = k % NUM_REQ;
            r = ref_op(pa[w], pb[w], ps[w]);
            #1 check("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << w));
            @(negedge clk);
            #1 check("rr_exec_ready", 64'(bus.req_ready), 64'(0));
            @(negedge clk);
            check("rr_valid", 64'(bus.rsp_valid), 64'(1));
            check("rr_id", 64'(bus.rsp_id), 64'(w));
            check("rr_sum", 64'(bus.rsp_sum), 64'(r[31:0]));
            check("rr_cout", 64'(bus.rsp_cout), 64'(r[32]));
            @(negedge clk);
            check("rr_done", 64'(bus.rsp_valid), 64'(0));
        end

        // Consumer stall of 10 cycles on requester 2's result (12+2=14)
        bus.rsp_ready = 1'b0;
        #1 check("stall_grant", 64'(bus.req_ready), 64'(4'b0100));
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1 check("stall_valid", 64'(bus.rsp_valid), 64'(1));
            check("stall_id", 64'(bus.rsp_id), 64'(2));
            check("stall_sum", 64'(bus.rsp_sum), 64'(14));
            check("stall_cout", 64'(bus.rsp_cout), 64'(0));
            check("stall_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 64'(bus.rsp_valid), 64'(0));
        #1 check("stall_next_grant", 64'(bus.req_ready), 64'(4'b1000));

        // Reset during EXEC discards requester 1 and rewinds the pointer
        do_reset();
        pend[1] = 1'b1;
        pack();
        #1 check("mid_grant1", 64'(bus.req_ready), 64'(4'b0010));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b1;
        pack();
        #1 check("mid_rst_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
        #1 check("mid_grant0", 64'(bus.req_ready), 64'(4'b0001));
        @(negedge clk);
        check("mid_no_rsp", 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        check("mid_id", 64'(bus.rsp_id), 64'(0));
        check("mid_sum", 64'(bus.rsp_sum), 64'(10));
        @(negedge clk);

        // Random traffic against a cycle-level round-robin model
        do_reset();
        m_state = 0; m_ptr = 0; m_id = 0; m_res = '0; n_ops = 0; cyc = 0;
        while (n_ops < N_RAND && cyc < 5000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = $urandom;
                    pb[i]   = $urandom;
                    ps[i]   = 1'($urandom_range(0, 1));
                end
            end
            pack();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            if (m_state == 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (w < 0 && pend[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
                end
            end
            exp_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
            check("rand_ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("rand_valid", 64'(bus.rsp_valid), 64'(m_state == 2));
            if (m_state == 2) begin
                check("rand_id", 64'(bus.rsp_id), 64'(m_id));
                check("rand_sum", 64'(bus.rsp_sum), 64'(m_res[31:0]));
                check("rand_cout", 64'(bus.rsp_cout), 64'(m_res[32]));
            end
            case (m_state)
                0: if (w >= 0) begin
                    m_id    = w;
                    m_res   = ref_op(pa[w], pb[w], ps[w]);
                    pend[w] = 1'b0;
                    m_ptr   = (w + 1) % NUM_REQ;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (bus.rsp_ready) begin
                    m_state = 0;
                    n_ops++;
                end
            endcase
            @(negedge clk);
            cyc++;
        end
        check("rand_ops_done", 64'(n_ops), 64'(N_RAND));

`ifdef KSA_ARB_OVF_EN
        do_reset();
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
        check("ovf_add_pos", 64'(bus.rsp_ovf), 64'(1));
        do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1);
        check("ovf_sub_neg", 64'(bus.rsp_ovf), 64'(1));
        do_op(2, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0);
        check("ovf_none", 64'(bus.rsp_ovf), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
